// File: rtl/terminal_cell_pkg.sv
// rtl/terminal_cell_pkg.sv - shared character-cell layout, encodings and buffer addressing
//
// Purpose: one place for the 32-bit character cell format and the SDRAM cell
// buffer layout, shared by the terminal stream writer and the row reader.
// Cell fields:
//   bg[31:28] fg[27:24] pattern[23:20] func[19:18] underline[17] invert[16]
//   blink[15:14] part[13:12] size[11:10] ord[9:0]
package terminal_cell_pkg;

    // Cell pitch per text row in the SDRAM cell buffer, in cells.
    localparam int REAL_WIDTH = 128;

    localparam int CELL_BG_MSB        = 31;
    localparam int CELL_BG_LSB        = 28;
    localparam int CELL_FG_MSB        = 27;
    localparam int CELL_FG_LSB        = 24;
    localparam int CELL_PATTERN_MSB   = 23;
    localparam int CELL_PATTERN_LSB   = 20;
    localparam int CELL_FUNC_MSB      = 19;
    localparam int CELL_FUNC_LSB      = 18;
    localparam int CELL_UNDERLINE_BIT = 17;
    localparam int CELL_INVERT_BIT    = 16;
    localparam int CELL_BLINK_MSB     = 15;
    localparam int CELL_BLINK_LSB     = 14;
    localparam int CELL_PART_MSB      = 13;
    localparam int CELL_PART_LSB      = 12;
    localparam int CELL_SIZE_MSB      = 11;
    localparam int CELL_SIZE_LSB      = 10;
    localparam int CELL_ORD_MSB       = 9;
    localparam int CELL_ORD_LSB       = 0;

    // Glyph scaling of a cell.
    localparam logic [1:0] SIZE_NORMAL = 2'd0;
    localparam logic [1:0] SIZE_WIDE   = 2'd1;
    localparam logic [1:0] SIZE_TALL   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    // Which quarter of an enlarged glyph this cell shows.
    localparam logic [1:0] PART_TOP_LEFT     = 2'd0;
    localparam logic [1:0] PART_TOP_RIGHT    = 2'd1;
    localparam logic [1:0] PART_BOTTOM_LEFT  = 2'd2;
    localparam logic [1:0] PART_BOTTOM_RIGHT = 2'd3;

    localparam logic [1:0] BLINK_NONE  = 2'd0;
    localparam logic [1:0] BLINK_SLOW  = 2'd1;
    localparam logic [1:0] BLINK_FAST  = 2'd2;
    localparam logic [1:0] BLINK_PHASE = 2'd3;

    // How the fill pattern combines with the glyph.
    localparam logic [1:0] LOGICAL_COPY = 2'd0;
    localparam logic [1:0] LOGICAL_OR   = 2'd1;
    localparam logic [1:0] LOGICAL_AND  = 2'd2;
    localparam logic [1:0] LOGICAL_XOR  = 2'd3;

    // Space, fg 15, bg 0, func OR, everything else zero.
    localparam logic [31:0] BLANK_CELL = 32'h0F04_0020;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_RECEIVE,
        ST_PAD,
        ST_COMPLETE
    } row_reader_state_e;

    // Byte address of cell (row, x): 4 * (REAL_WIDTH * row + x).
    function automatic logic [22:0] address_from_position(input logic [5:0] row,
                                                          input logic [6:0] x);
        return {8'b0, row, x, 2'b00};
    endfunction

endpackage

// File: rtl/cell_line_buffer.sv
// rtl/cell_line_buffer.sv - two-bank line buffer with one write port and a registered read port
//
// Purpose: holds two rows of cells (front/back), REAL_WIDTH entries per bank.
// Ports:
//   clk, reset_n                      clock, async active-low reset (read register only)
//   wr_en, wr_bank, wr_index, wr_data write port
//   rd_bank, rd_index                 read address
//   rd_data                           registered read data, 0 after reset
module cell_line_buffer
    import terminal_cell_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic        wr_bank,
    input  logic [6:0]  wr_index,
    input  logic [31:0] wr_data,
    input  logic        rd_bank,
    input  logic [6:0]  rd_index,
    output logic [31:0] rd_data
);

    logic [31:0] mem_q [0:2*REAL_WIDTH-1];
    logic [31:0] rd_data_d;
    logic [31:0] rd_data_q;

    // Storage contents are left unreset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank, wr_index}] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem_q[{rd_bank, rd_index}];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cell_row_reader.sv
// rtl/cell_row_reader.sv - burst-fetches one text row of cells into a double-buffered line buffer
//
// Purpose: on row_request, reads COLUMNS cells of a row from the SDRAM cell
// buffer into the back bank, padding short bursts with BLANK_CELL. row_swap
// exchanges banks; the video side reads the front bank with 1-cycle latency.
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   row_request, row_index                fetch command
//   row_busy, row_ready                   fetch status
//   row_swap                              bank exchange pulse
//   cell_x, cell_data                     video read port (registered)
//   rd_address, rd_request, rd_burst_length  SDRAM read command
//   rd_data, rd_data_valid, rd_done       SDRAM read response
module cell_row_reader
    import terminal_cell_pkg::*;
#(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 51
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        row_request,
    input  logic [5:0]  row_index,
    output logic        row_busy,
    output logic        row_ready,
    input  logic        row_swap,
    input  logic [6:0]  cell_x,
    output logic [31:0] cell_data,
    output logic [22:0] rd_address,
    output logic        rd_request,
    output logic [8:0]  rd_burst_length,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        rd_done
);

    localparam logic [7:0] COLS_W = 8'(COLUMNS);
    localparam logic [6:0] ROWS_W = 7'(ROWS);

    row_reader_state_e state_d, state_q;
    logic [5:0]  row_d, row_q;
    logic [7:0]  cnt_d, cnt_q;
    logic        busy_d, busy_q;
    logic        ready_d, ready_q;
    logic        front_d, front_q;
    logic        oob_d, oob_q;

    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] buf_rd_data;
    logic        swap_ok;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        front_d = front_q;
        wr_en   = 1'b0;
        wr_data = rd_data;

        // Swap is evaluated before the FSM so a coincident request in IDLE
        // fetches into the bank that has just become the back bank.
        swap_ok = row_swap && ready_q && !busy_q;
        if (swap_ok) begin
            front_d = ~front_q;
            ready_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (row_request && !busy_q) begin
                    row_d   = ({1'b0, row_index} >= ROWS_W) ? 6'd0 : row_index;
                    cnt_d   = 8'd0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                state_d = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                if (rd_data_valid && (cnt_q < COLS_W)) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
                // cnt_d already includes a word arriving together with rd_done.
                if (rd_done) begin
                    state_d = (cnt_d == COLS_W) ? ST_COMPLETE : ST_PAD;
                end
            end
            ST_PAD: begin
                if (cnt_q < COLS_W) begin
                    wr_en   = 1'b1;
                    wr_data = BLANK_CELL;
                    cnt_d   = cnt_q + 8'd1;
                end
                if (cnt_d == COLS_W) begin
                    state_d = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        oob_d = ({1'b0, cell_x} >= COLS_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            front_q <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            front_q <= front_d;
            oob_q   <= oob_d;
        end
    end

    cell_line_buffer u_line_buffer (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_bank  (~front_q),
        .wr_index (cnt_q[6:0]),
        .wr_data  (wr_data),
        .rd_bank  (front_q),
        .rd_index (cell_x),
        .rd_data  (buf_rd_data)
    );

    // Out-of-range columns are flagged alongside the registered read so both
    // line up on the same cycle.
    assign cell_data       = oob_q ? BLANK_CELL : buf_rd_data;
    assign rd_request      = (state_q == ST_REQUEST);
    assign rd_address      = address_from_position(row_q, 7'd0);
    assign rd_burst_length = 9'(COLUMNS);
    assign row_busy        = busy_q;
    assign row_ready       = ready_q;

endmodule

// File: tb/tb_cell_row_reader.sv
// tb/tb_cell_row_reader.sv - self-checking bench for cell_row_reader
module tb_cell_row_reader;

    localparam logic [31:0] BLANK = 32'h0F04_0020;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        row_request;
    logic [5:0]  row_index;
    logic        row_busy;
    logic        row_ready;
    logic        row_swap;
    logic [6:0]  cell_x;
    logic [31:0] cell_data;
    logic [22:0] rd_address;
    logic        rd_request;
    logic [8:0]  rd_burst_length;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rd_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          phase;
        logic [6:0]  x;
        logic [31:0] exp;
    } read_vec_t;

    read_vec_t   vecs[$];
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    cell_row_reader dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .row_request     (row_request),
        .row_index       (row_index),
        .row_busy        (row_busy),
        .row_ready       (row_ready),
        .row_swap        (row_swap),
        .cell_x          (cell_x),
        .cell_data       (cell_data),
        .rd_address      (rd_address),
        .rd_request      (rd_request),
        .rd_burst_length (rd_burst_length),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .rd_done         (rd_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int p, input int x, input logic [31:0] e);
        read_vec_t v;
        v.phase = p;
        v.x     = 7'(x);
        v.exp   = e;
        vecs.push_back(v);
    endtask

    // Presents each column of one phase, queues the expected cell, and
    // compares it one cycle later when the registered read appears.
    task automatic run_phase(input int p);
        logic [31:0] e;
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                cell_x = vecs[i].x;
                sb_q.push_back(vecs[i].exp);
                tick();
                e = sb_q.pop_front();
                check($sformatf("cell_data p%0d x%0d", p, vecs[i].x), cell_data, e);
            end
        end
    endtask

    task automatic swap();
        row_swap = 1'b1;
        tick();
        row_swap = 1'b0;
        check("row_ready after swap", 32'(row_ready), 32'd0);
    endtask

    // SDRAM model: answers one burst with base+k words. Optionally raises a
    // second row_request mid-burst and a row_swap together with the request.
    task automatic do_fetch(input logic [5:0] row, input logic [22:0] exp_addr,
                            input int nwords, input logic [31:0] base,
                            input bit done_with_last, input bit extra_req,
                            input bit with_swap);
        bit found = 0;
        int pulses = 0;
        row_index   = row;
        row_request = 1'b1;
        row_swap    = with_swap;
        tick();
        row_request = 1'b0;
        row_swap    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rd_request) begin
                found = 1;
                break;
            end
            tick();
        end
        check("rd_request seen", 32'(found), 32'd1);
        if (found) pulses = 1;
        check("rd_address", 32'(rd_address), 32'(exp_addr));
        check("rd_burst_length", 32'(rd_burst_length), 32'd80);
        check("row_busy during fetch", 32'(row_busy), 32'd1);
        tick();
        for (int k = 0; k < nwords; k++) begin
            if (rd_request) pulses++;
            row_request   = extra_req && (k == 5);
            row_index     = extra_req ? 6'd7 : row;
            rd_data_valid = 1'b1;
            rd_data       = base + 32'(k);
            rd_done       = done_with_last && (k == nwords - 1);
            tick();
        end
        row_request   = 1'b0;
        rd_data_valid = 1'b0;
        if (!done_with_last) begin
            rd_done = 1'b1;
            tick();
        end
        rd_done = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (rd_request) pulses++;
            if (row_ready) begin
                found = 1;
                break;
            end
            tick();
        end
        check("row_ready rises", 32'(found), 32'd1);
        check("row_busy after fetch", 32'(row_busy), 32'd0);
        check("rd_request pulses", 32'(pulses), 32'd1);
        check("rd_address held", 32'(rd_address), 32'(exp_addr));
    endtask

    initial begin
        add_vec(1, 0, 32'h100);
        add_vec(1, 5, 32'h105);
        add_vec(1, 79, 32'h14F);
        add_vec(1, 80, BLANK);
        add_vec(1, 100, BLANK);
        add_vec(1, 127, BLANK);
        add_vec(2, 0, 32'h200);
        add_vec(2, 77, 32'h24D);
        add_vec(2, 78, BLANK);
        add_vec(2, 79, BLANK);
        add_vec(3, 0, 32'h300);
        add_vec(3, 1, 32'h301);
        add_vec(4, 0, 32'h400);
        add_vec(5, 0, 32'h500);
        add_vec(5, 79, 32'h54F);
        add_vec(6, 0, 32'h600);
        add_vec(6, 79, 32'h64F);

        reset_n       = 1'b0;
        row_request   = 1'b0;
        row_index     = '0;
        row_swap      = 1'b0;
        cell_x        = '0;
        rd_data       = '0;
        rd_data_valid = 1'b0;
        rd_done       = 1'b0;
        tick();
        tick();
        check("reset rd_request", 32'(rd_request), 32'd0);
        check("reset rd_address", 32'(rd_address), 32'd0);
        check("reset rd_burst_length", 32'(rd_burst_length), 32'd80);
        check("reset row_busy", 32'(row_busy), 32'd0);
        check("reset row_ready", 32'(row_ready), 32'd0);
        check("reset cell_data", cell_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // Full burst of row 3.
        do_fetch(6'd3, 23'h00_0600, 80, 32'h100, 1'b1, 1'b0, 1'b0);
        swap();
        run_phase(1);

        // Short burst: 78 words then rd_done on its own cycle.
        do_fetch(6'd4, 23'h00_0800, 78, 32'h200, 1'b0, 1'b0, 1'b0);
        swap();
        run_phase(2);

        // Request for row 7 while row 2 is in flight is ignored.
        do_fetch(6'd2, 23'h00_0400, 80, 32'h300, 1'b1, 1'b1, 1'b0);
        swap();
        row_swap = 1'b1;
        tick();
        row_swap = 1'b0;
        run_phase(3);

        // Out-of-range row maps to row 0.
        do_fetch(6'd60, 23'h00_0000, 80, 32'h400, 1'b1, 1'b0, 1'b0);

        // Swap and request together: front becomes row 60, row 5 lands in the
        // bank that just left the front.
        do_fetch(6'd5, 23'h00_0A00, 80, 32'h500, 1'b1, 1'b0, 1'b1);
        run_phase(4);
        swap();
        run_phase(5);

        // Reset in the middle of RECEIVE.
        row_index   = 6'd9;
        row_request = 1'b1;
        tick();
        row_request = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            rd_data_valid = 1'b1;
            rd_data       = 32'hDEAD_0000 + 32'(k);
            tick();
        end
        reset_n = 1'b0;
        #1;
        check("midreset rd_request", 32'(rd_request), 32'd0);
        check("midreset row_busy", 32'(row_busy), 32'd0);
        check("midreset row_ready", 32'(row_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        rd_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stray response rd_request", 32'(rd_request), 32'd0);
            check("stray response row_busy", 32'(row_busy), 32'd0);
            check("stray response row_ready", 32'(row_ready), 32'd0);
        end
        rd_data_valid = 1'b0;
        rd_done       = 1'b0;
        tick();
        do_fetch(6'd1, 23'h00_0200, 80, 32'h600, 1'b1, 1'b0, 1'b0);
        swap();
        run_phase(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cell_row_reader.md
Name: cell_row_reader

Overview:
Reads one text row of 32-bit character cells from the SDRAM cell buffer and holds it for the video generator. The cell buffer is filled by the terminal stream writer. Rows are fetched by burst read into the back bank of a double-buffered line buffer. The video side reads the front bank by column index with 1-cycle latency. Sits between the SDRAM read port and the character/glyph rendering pipeline.

Parameters:
COLUMNS, 80, visible cells per row and burst length.
ROWS, 51, number of text rows.
REAL_WIDTH, 128, cell pitch per row in SDRAM (cells).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
row_request  in  1  one-cycle pulse: fetch row row_index into back bank
row_index  in  6  text row to fetch
row_busy  out  1  fetch in progress
row_ready  out  1  back bank holds a complete row, not yet swapped
row_swap  in  1  one-cycle pulse: back bank becomes front bank
cell_x  in  7  column read by video side
cell_data  out  32  cell at cell_x in front bank, registered
rd_address  out  23  SDRAM byte address
rd_request  out  1  read request strobe
rd_burst_length  out  9  words in burst
rd_data  in  32  returned word
rd_data_valid  in  1  rd_data valid this cycle
rd_done  in  1  burst complete

Behaviour:
- Reset values: rd_request 0, rd_address 0, rd_burst_length COLUMNS, row_busy 0, row_ready 0, cell_data 0, front bank = 0, state IDLE. Line buffer contents are undefined.
- Address rule: rd_address = {8'b0, row[5:0], 7'b0, 2'b00}. This is the writer's layout, byte address = 4*(REAL_WIDTH*row + x).
- row_index >= ROWS is fetched as row 0.
- State machine:
  - IDLE: on row_request, latch the row, clear word counter, clear row_ready, set row_busy, go to REQUEST. If row_busy is already set, row_request is ignored.
  - REQUEST: drive rd_request=1, rd_address, rd_burst_length=COLUMNS for exactly one cycle, then go to RECEIVE.
  - RECEIVE: on each rd_data_valid, write rd_data to back[counter] and increment counter.
    - Words arriving after counter reaches COLUMNS are dropped.
    - On rd_done with counter == COLUMNS, go to COMPLETE.
    - On rd_done with counter < COLUMNS (short burst), go to PAD.
  - PAD: write BLANK_CELL to back[counter] one per cycle until counter == COLUMNS, then go to COMPLETE.
  - COMPLETE: clear row_busy, set row_ready, go to IDLE.
- rd_data_valid and rd_done in the same cycle: store the word first, then evaluate the counter including that word.
- BLANK_CELL = 32'h0F04_0020: space, fg 15, bg 0, func OR, all other fields zero.
- row_swap:
  - Honoured only when row_ready=1 and row_busy=0: toggles the front bank and clears row_ready, effective the next cycle.
  - Otherwise ignored, front bank unchanged.
  - row_swap coinciding with row_request in IDLE: the swap happens first, and the fetch targets the new back bank.
- Read side: cell_data <= front[cell_x] one cycle after cell_x is presented. cell_x >= COLUMNS returns BLANK_CELL. Reads never stall and are independent of fetch activity.
- Asynchronous reset mid-burst: return to IDLE immediately and drop rd_request. Later rd_data_valid/rd_done are ignored until the next REQUEST.
- Widths: word counter 8 bits; row latch 6 bits. Comparisons against COLUMNS are unsigned.

Decomposition:
- Shared package terminal_cell_pkg holds:
  - cell field positions: bg[31:28], fg[27:24], pattern[23:20], func[19:18], underline 17, invert 16, blink[15:14], part[13:12], size[11:10], ord[9:0];
  - SIZE_*, PART_*, BLINK_*, LOGICAL_* encodings;
  - REAL_WIDTH, BLANK_CELL;
  - an address_from_position function shared with the writer.
- One sub-module: cell_line_buffer, with 2 banks of REAL_WIDTH x 32, one write port (bank, index, data, we) and one registered read port (bank, index).

Test Plan:
- Fetch row 3 with the SDRAM model returning words k = 0x100+k, then swap → rd_address = 0x00_0600, burst 80; row_ready rises; cell_x=5 gives 0x105 one cycle later.
- Short burst: 78 words then rd_done → cells 78 and 79 read 0x0F04_0020; row_ready set after padding completes.
- row_request while row_busy (row 7 during fetch of row 2) → only one rd_request pulse, address 0x00_0400.
- row_swap with row_ready=0 → front bank unchanged; cell_x=0 still returns the old row data.
- row_index=60 → rd_address 0. cell_x=100 → cell_data 0x0F04_0020.
- reset_n low mid-RECEIVE → rd_request 0, row_busy 0, row_ready 0; a fresh fetch of row 1 afterwards completes correctly (address 0x00_0200).
